// File: rtl/memlog_pkg.sv
// Shared encodings for the sample-logger capture/dump sequencer.
package memlog_pkg;

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_CAPTURE = 2'b01;
    localparam logic [1:0] CMD_DUMP    = 2'b10;
    localparam logic [1:0] CMD_ABORT   = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARM       = 3'd1;
    localparam logic [2:0] ST_WAIT_FULL = 3'd2;
    localparam logic [2:0] ST_CAPTURED  = 3'd3;
    localparam logic [2:0] ST_RD_ARM    = 3'd4;
    localparam logic [2:0] ST_RD_ADDR   = 3'd5;
    localparam logic [2:0] ST_RD_WAIT   = 3'd6;
    localparam logic [2:0] ST_RD_OUT    = 3'd7;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StArm      = ST_ARM,
        StWaitFull = ST_WAIT_FULL,
        StCaptured = ST_CAPTURED,
        StRdArm    = ST_RD_ARM,
        StRdAddr   = ST_RD_ADDR,
        StRdWait   = ST_RD_WAIT,
        StRdOut    = ST_RD_OUT
    } state_t;

    // Extra cycles granted beyond one full buffer before a capture is declared stuck.
    localparam int unsigned TMO_MARGIN = 16;

endpackage

// File: rtl/memlog_rd_pipe.sv
// Read stage of the dump sweep: address register, read-latency countdown and
// a held output word on a valid/ready stream.
module memlog_rd_pipe #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              abort,
    input  logic              load,
    input  logic              count,
    input  logic [DATA_W-1:0] log_data,
    input  logic              ready,
    output logic              fire,
    output logic              hs,
    output logic              last,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    logic [CNT_W-1:0] lat_cnt;
    logic             valid_r;

    assign last  = (addr == '1);
    assign fire  = count & ~abort & (lat_cnt == CNT_W'(1));
    // Abort withdraws the word in the same cycle so no handshake can complete.
    assign hs    = valid_r & ready & ~abort;
    assign valid = valid_r & ~abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            data    <= '0;
            valid_r <= 1'b0;
            lat_cnt <= '0;
        end else if (abort) begin
            valid_r <= 1'b0;
            lat_cnt <= '0;
        end else if (clear) begin
            addr    <= '0;
            valid_r <= 1'b0;
            lat_cnt <= '0;
        end else begin
            if (load) begin
                lat_cnt <= CNT_W'(RD_LAT);
            end else if (count && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (fire) begin
                data    <= log_data;
                valid_r <= 1'b1;
            end else if (hs) begin
                valid_r <= 1'b0;
                if (!last) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memlog_seq_ctrl.sv
// Host-command sequencer: arms a logger capture, waits for full (with timeout),
// then sweeps every logger address onto the dump stream.
module memlog_seq_ctrl
    import memlog_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned TMO_W  = 24
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_mem_full,
    input  logic [31:0]       i_log_data,
    output logic              o_run_log,
    output logic              o_read_log,
    output logic [ADDR_W-1:0] o_addr_log,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic              o_busy,
    output logic              o_captured,
    output logic              o_err_tmo
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'((1 << ADDR_W) + TMO_MARGIN);

    state_t           state;
    logic             ready_en;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_rd;
    logic             accept;
    logic             cmd_capture;
    logic             cmd_dump;
    logic             cmd_abort;
    logic             abort_rd;
    logic             pipe_fire;
    logic             pipe_hs;
    logic             pipe_last;
    logic             unused_log_bits;

    assign unused_log_bits = ^i_log_data[31:DATA_W];

    // Ready is held low for the first cycle out of reset so every output reads 0.
    assign o_cmd_ready = ready_en & (state != StArm);
    assign o_busy      = (state != StIdle) & (state != StCaptured);
    assign in_rd       = (state == StRdArm) | (state == StRdAddr) |
                         (state == StRdWait) | (state == StRdOut);
    assign accept      = i_cmd_valid & o_cmd_ready;
    assign cmd_capture = accept & (i_cmd == CMD_CAPTURE);
    assign cmd_dump    = accept & (i_cmd == CMD_DUMP);
    assign cmd_abort   = accept & (i_cmd == CMD_ABORT);
    assign abort_rd    = cmd_abort & in_rd;

    memlog_rd_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (i_rst),
        .clear    (cmd_dump & (state == StCaptured)),
        .abort    (abort_rd),
        .load     (state == StRdAddr),
        .count    (state == StRdWait),
        .log_data (i_log_data[DATA_W-1:0]),
        .ready    (i_dump_ready),
        .fire     (pipe_fire),
        .hs       (pipe_hs),
        .last     (pipe_last),
        .addr     (o_addr_log),
        .data     (o_dump_data),
        .valid    (o_dump_valid)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= StIdle;
            ready_en   <= 1'b0;
            tmo_cnt    <= '0;
            o_run_log  <= 1'b0;
            o_read_log <= 1'b0;
            o_captured <= 1'b0;
            o_err_tmo  <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            o_run_log  <= 1'b0;
            o_read_log <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_capture) begin
                        state      <= StArm;
                        o_run_log  <= 1'b1;
                        tmo_cnt    <= '0;
                        o_captured <= 1'b0;
                        o_err_tmo  <= 1'b0;
                    end
                end
                StArm: state <= StWaitFull;
                StWaitFull: begin
                    if (cmd_abort) begin
                        state <= StIdle;
                    end else if (i_mem_full) begin
                        state      <= StCaptured;
                        o_captured <= 1'b1;
                    end else if (tmo_cnt == TMO_LIMIT - 1'b1) begin
                        state     <= StIdle;
                        o_err_tmo <= 1'b1;
                    end
                    if (tmo_cnt != TMO_LIMIT) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StCaptured: begin
                    if (cmd_capture) begin
                        state      <= StArm;
                        o_run_log  <= 1'b1;
                        tmo_cnt    <= '0;
                        o_captured <= 1'b0;
                        o_err_tmo  <= 1'b0;
                    end else if (cmd_dump) begin
                        state      <= StRdArm;
                        o_read_log <= 1'b1;
                    end else if (cmd_abort) begin
                        state      <= StIdle;
                        o_captured <= 1'b0;
                    end
                end
                StRdArm:  state <= cmd_abort ? StCaptured : StRdAddr;
                StRdAddr: state <= cmd_abort ? StCaptured : StRdWait;
                StRdWait: begin
                    if (cmd_abort) begin
                        state <= StCaptured;
                    end else if (pipe_fire) begin
                        state <= StRdOut;
                    end
                end
                StRdOut: begin
                    if (cmd_abort) begin
                        state <= StCaptured;
                    end else if (pipe_hs) begin
                        state <= pipe_last ? StCaptured : StRdAddr;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memlog_seq_ctrl.sv
// Directed bench for memlog_seq_ctrl with a small delayed-read logger model.
module tb_memlog_seq_ctrl;
    import memlog_pkg::*;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned TMO_W  = 24;
    localparam int unsigned WORDS  = 1 << ADDR_W;

    logic              clk;
    logic              i_rst;
    logic              i_cmd_valid;
    logic [1:0]        i_cmd;
    logic              o_cmd_ready;
    logic              i_mem_full;
    logic [31:0]       i_log_data;
    logic              o_run_log;
    logic              o_read_log;
    logic [ADDR_W-1:0] o_addr_log;
    logic [DATA_W-1:0] o_dump_data;
    logic              o_dump_valid;
    logic              i_dump_ready;
    logic              o_busy;
    logic              o_captured;
    logic              o_err_tmo;

    int tests;
    int fails;
    int cyc;

    memlog_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .TMO_W  (TMO_W)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .o_cmd_ready  (o_cmd_ready),
        .i_mem_full   (i_mem_full),
        .i_log_data   (i_log_data),
        .o_run_log    (o_run_log),
        .o_read_log   (o_read_log),
        .o_addr_log   (o_addr_log),
        .o_dump_data  (o_dump_data),
        .o_dump_valid (o_dump_valid),
        .i_dump_ready (i_dump_ready),
        .o_busy       (o_busy),
        .o_captured   (o_captured),
        .o_err_tmo    (o_err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Logger model: word = addr * 0x0101 with junk in the unused upper half.
    logic [31:0] lp [RD_LAT];
    always @(posedge clk) begin
        lp[0] <= {16'hA5A5, 4'h0, o_addr_log, 4'h0, o_addr_log};
        for (int k = 1; k < RD_LAT; k++) lp[k] <= lp[k-1];
    end
    assign i_log_data = lp[RD_LAT-1];

    typedef struct {
        logic       cv;
        logic [1:0] cmd;
        logic       full;
        int         reps;
        logic [6:0] exp;  // {ready, busy, run, read, captured, err, valid}
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic cv, input logic [1:0] cmd, input logic full,
                                input int reps, input logic [6:0] exp);
        vec_t v;
        v.cv   = cv;
        v.cmd  = cmd;
        v.full = full;
        v.reps = reps;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {o_cmd_ready, o_busy, o_run_log, o_read_log, o_captured, o_err_tmo, o_dump_valid};
    endfunction

    // stop_kind: 0 = run to completion, 1 = ABORT at stop_word, 2 = reset at stop_word
    task automatic do_dump(input int pct, input int stop_word, input int stop_kind);
        int idx;
        int reads;
        int runs;
        int last_hs;
        int n;
        logic pv;
        logic pr;
        logic [15:0] pd;
        idx = 0; reads = 0; runs = 0; last_hs = 0; n = 0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd = CMD_DUMP; i_dump_ready = 1'b0;
        #1;
        check("dump_from_captured", {o_cmd_ready, o_captured, o_busy}, 3'b110);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        check("rd_arm_pulse", {o_read_log, o_run_log, o_busy}, 3'b101);
        check("rd_arm_addr", o_addr_log, 0);
        reads = 1;
        while (idx < WORDS && n < 2000) begin
            @(negedge clk);
            n++;
            i_dump_ready = ($urandom_range(99) < pct);
            #1;
            if (o_read_log) reads++;
            if (o_run_log) runs++;
            if (pv && !pr) check("hold_stable", {o_dump_valid, o_dump_data}, {1'b1, pd});
            if (o_dump_valid && stop_kind != 0 && idx == stop_word) begin
                if (stop_kind == 1) begin
                    i_cmd_valid = 1'b1; i_cmd = CMD_ABORT; i_dump_ready = 1'b1;
                    #1;
                    check("abort_drops_valid", o_dump_valid, 0);
                    @(negedge clk);
                    i_cmd_valid = 1'b0; i_dump_ready = 1'b0;
                    #1;
                    check("abort_to_captured", {o_captured, o_busy, o_dump_valid, o_cmd_ready},
                          4'b1001);
                end else begin
                    i_rst = 1'b1;
                    @(negedge clk);
                    i_rst = 1'b0; i_dump_ready = 1'b0;
                    #1;
                    check("reset_mid_dump_ctrl", ctrl_vec(), 0);
                    check("reset_mid_dump_addr", o_addr_log, 0);
                    check("reset_mid_dump_data", o_dump_data, 0);
                end
                return;
            end
            if (o_dump_valid && i_dump_ready) begin
                check($sformatf("word%0d", idx), o_dump_data, 16'(idx * 257));
                if (pct >= 100 && idx > 0) check("word_spacing", cyc - last_hs, RD_LAT + 2);
                last_hs = cyc;
                idx++;
            end
            pv = o_dump_valid; pr = i_dump_ready; pd = o_dump_data;
        end
        check("dump_complete", idx, WORDS);
        check("single_read_pulse", reads, 1);
        check("no_run_in_dump", runs, 0);
        @(negedge clk);
        i_dump_ready = 1'b0;
        #1;
        check("after_dump", {o_captured, o_busy, o_dump_valid, o_cmd_ready}, 4'b1001);
    endtask

    task automatic capture_full();
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd = CMD_CAPTURE;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        check("cap_arm", {o_run_log, o_busy, o_captured}, 3'b110);
        @(negedge clk);
        i_mem_full = 1'b1;
        @(negedge clk);
        i_mem_full = 1'b0;
        #1;
        check("cap_done", {o_captured, o_busy}, 2'b10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0;
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = CMD_NOP; i_mem_full = 1'b0;
        i_dump_ready = 1'b0;

        tbl[0]  = mk(1'b1, CMD_CAPTURE, 1'b0, 1,  7'b1000000);
        tbl[1]  = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b0110000);
        tbl[2]  = mk(1'b1, CMD_DUMP,    1'b0, 1,  7'b1100000);
        tbl[3]  = mk(1'b1, CMD_CAPTURE, 1'b0, 1,  7'b1100000);
        tbl[4]  = mk(1'b0, CMD_NOP,     1'b0, 13, 7'b1100000);
        tbl[5]  = mk(1'b0, CMD_NOP,     1'b1, 1,  7'b1100000);
        tbl[6]  = mk(1'b1, CMD_NOP,     1'b0, 1,  7'b1000100);
        tbl[7]  = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b1000100);
        tbl[8]  = mk(1'b1, CMD_ABORT,   1'b0, 1,  7'b1000100);
        tbl[9]  = mk(1'b1, CMD_DUMP,    1'b0, 1,  7'b1000000);
        tbl[10] = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b1000000);
        tbl[11] = mk(1'b1, CMD_ABORT,   1'b0, 1,  7'b1000000);
        tbl[12] = mk(1'b1, CMD_CAPTURE, 1'b0, 1,  7'b1000000);
        tbl[13] = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b0110000);
        tbl[14] = mk(1'b1, CMD_ABORT,   1'b0, 1,  7'b1100000);
        tbl[15] = mk(1'b1, CMD_CAPTURE, 1'b0, 1,  7'b1000000);
        tbl[16] = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b0110000);
        tbl[17] = mk(1'b0, CMD_NOP,     1'b1, 1,  7'b1100000);
        tbl[18] = mk(1'b0, CMD_NOP,     1'b0, 1,  7'b1000100);

        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check("reset_ctrl", ctrl_vec(), 0);
        check("reset_addr", o_addr_log, 0);
        check("reset_data", o_dump_data, 0);

        for (int i = 0; i < 19; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(negedge clk);
                i_cmd_valid = tbl[i].cv;
                i_cmd       = tbl[i].cmd;
                i_mem_full  = tbl[i].full;
                #1;
                check($sformatf("vec%0d", i), ctrl_vec(), tbl[i].exp);
            end
        end

        do_dump(100, -1, 0);
        do_dump(30, -1, 0);
        do_dump(100, 7, 1);
        do_dump(100, -1, 0);

        // Capture timeout: 32 cycles in WAIT_FULL with the buffer never filling.
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd = CMD_CAPTURE;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        check("tmo_arm", {o_run_log, o_captured, o_err_tmo}, 3'b100);
        repeat (32) @(negedge clk);
        #1;
        check("tmo_wait32", {o_busy, o_err_tmo}, 2'b10);
        @(negedge clk);
        #1;
        check("tmo_flag", {o_err_tmo, o_busy, o_captured, o_cmd_ready}, 4'b1001);
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd = CMD_CAPTURE;
        #1;
        check("tmo_sticky", o_err_tmo, 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        check("tmo_clear", {o_run_log, o_err_tmo}, 2'b10);
        @(negedge clk);
        i_mem_full = 1'b1;
        @(negedge clk);
        i_mem_full = 1'b0;
        #1;
        check("tmo_recapture", {o_captured, o_busy}, 2'b10);

        do_dump(100, 5, 2);
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd = CMD_DUMP;
        #1;
        check("post_reset_ready", o_cmd_ready, 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
        check("dump_ignored", {o_read_log, o_busy, o_captured, o_dump_valid}, 0);
        capture_full();
        do_dump(100, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
